// File: rtl/echo_tap_scheduler_pkg.sv
// echo_sched_pkg: scheduler state enum, read-tag struct and saturating-sum helper shared by echo_tap_scheduler
package echo_sched_pkg;
    localparam int TAG_IDX_W = 8;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} sched_state_t;
    typedef struct packed {
        logic [TAG_IDX_W-1:0] idx;
        logic                 live;
    } tap_tag_t;
    function automatic logic signed [31:0] sat_sum(input logic signed [31:0] s, input int dw);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (dw - 1));
        return s > hi ? hi : (s < lo ? lo : s);
    endfunction
endpackage

// File: rtl/echo_tap_scheduler_if.sv
// echo_tap_scheduler_if: audio BRAM bundle; master drives port A write (we/w_addr/wdata) and port B read address, receives rdata
interface echo_tap_scheduler_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  we_out;
    logic [ADDR_WIDTH-1:0] w_addr_out;
    logic [DATA_WIDTH-1:0] wdata_out;
    logic [ADDR_WIDTH-1:0] r_addr_out;
    logic [DATA_WIDTH-1:0] rdata_in;
    modport master (output we_out, w_addr_out, wdata_out, r_addr_out, input rdata_in);
    modport slave (input we_out, w_addr_out, wdata_out, r_addr_out, output rdata_in);
endinterface

// File: rtl/echo_tap_scheduler_rd_tag_pipe.sv
// rd_tag_pipe: DEPTH-stage shift register of valid + tap_tag_t aligning read tags with BRAM data (clk_in, rst_n_in, in_valid/in_tag -> out_valid/out_tag)
module rd_tag_pipe
    import echo_sched_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk_in,
    input  logic     rst_n_in,
    input  logic     in_valid,
    input  tap_tag_t in_tag,
    output logic     out_valid,
    output tap_tag_t out_tag
);
    localparam int TW = $bits(tap_tag_t);
    localparam int PW = DEPTH * TW;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    tag_q, tag_d;
    always_comb begin
        vld_d     = DEPTH'({vld_q, in_valid});
        tag_d     = PW'({tag_q, in_tag});
        out_valid = vld_q[DEPTH-1];
        out_tag   = tap_tag_t'(tag_q[PW-1 -: TW]);
    end
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vld_q <= '0;
            tag_q <= '0;
        end else begin
            vld_q <= vld_d;
            tag_q <= tag_d;
        end
    end
endmodule

// File: rtl/echo_tap_scheduler.sv
// echo_tap_scheduler: records strobed samples into the BRAM and, per playback strobe, reads NUM_TAPS delayed taps into one frame with a saturated mix (clk_in, rst_n_in, audio/record/tap controls in; bram bus; tap_sample/mix/frame_valid/busy/overrun out)
module echo_tap_scheduler
    import echo_sched_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_TAPS     = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic                           audio_valid_in,
    input  logic signed [DATA_WIDTH-1:0]   audio_in,
    input  logic                           record_in,
    input  logic [NUM_TAPS*ADDR_WIDTH-1:0] tap_delay_in,
    input  logic [NUM_TAPS-1:0]            tap_en_in,
    echo_tap_scheduler_if.master           bram,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] tap_sample_out,
    output logic signed [DATA_WIDTH-1:0]   mix_out,
    output logic                           frame_valid_out,
    output logic                           busy_out,
    output logic                           overrun_out
);
    localparam int IW = NUM_TAPS > 1 ? $clog2(NUM_TAPS) : 1;
    localparam int SW = DATA_WIDTH + $clog2(NUM_TAPS) + 1;
    sched_state_t                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]          wptr_q, wptr_d, play_ptr_q, play_ptr_d, snap_q, snap_d, r_addr_q, r_addr_d;
    logic                           wrapped_q, wrapped_d, rec_q, rec_d;
    logic [IW-1:0]                  idx_q, idx_d;
    logic [NUM_TAPS*DATA_WIDTH-1:0] tap_q, tap_d;
    logic                           play_stb, we, issue, out_valid;
    logic [ADDR_WIDTH-1:0]          delay_k, rd_addr;
    logic signed [SW-1:0]           sum;
    tap_tag_t                       in_tag, out_tag;
    rd_tag_pipe #(.DEPTH(READ_LATENCY)) u_pipe (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .in_valid  (issue),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_tag   (out_tag)
    );
    always_comb begin
        play_stb    = audio_valid_in && !record_in;
        we          = rst_n_in && record_in && audio_valid_in;
        issue       = state_q == ISSUE;
        delay_k     = tap_delay_in[idx_q*ADDR_WIDTH +: ADDR_WIDTH];
        rd_addr     = snap_q - delay_k;
        in_tag.idx  = TAG_IDX_W'(idx_q);
        // taps reaching before the first recorded sample read as silence until the play head has wrapped once
        in_tag.live = tap_en_in[idx_q] && (wrapped_q || delay_k <= snap_q);
        state_d     = state_q;
        idx_d       = idx_q;
        snap_d      = snap_q;
        r_addr_d    = r_addr_q;
        tap_d       = tap_q;
        case (state_q)
            IDLE: begin
                state_d = play_stb ? ISSUE : IDLE;
                snap_d  = play_stb ? play_ptr_q : snap_q;
                idx_d   = '0;
            end
            ISSUE: begin
                r_addr_d = rd_addr;
                idx_d    = idx_q + 1'b1;
                state_d  = idx_q == IW'(NUM_TAPS - 1) ? DRAIN : ISSUE;
            end
            DRAIN:   state_d = out_valid && out_tag.idx == TAG_IDX_W'(NUM_TAPS - 1) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
        if (out_valid)
            tap_d[out_tag.idx*DATA_WIDTH +: DATA_WIDTH] = out_tag.live ? bram.rdata_in : '0;
        rec_d      = record_in;
        wptr_d     = wptr_q + ADDR_WIDTH'(we);
        play_ptr_d = record_in && !rec_q ? '0 : play_ptr_q + ADDR_WIDTH'(play_stb);
        wrapped_d  = record_in && !rec_q ? 1'b0 : wrapped_q || (play_stb && &play_ptr_q);
        sum = '0;
        for (int k = 0; k < NUM_TAPS; k++)
            sum = sum + SW'(signed'(tap_q[k*DATA_WIDTH +: DATA_WIDTH]));
        mix_out         = DATA_WIDTH'(sat_sum(32'(sum), DATA_WIDTH));
        bram.we_out     = we;
        bram.w_addr_out = wptr_q;
        bram.wdata_out  = we ? audio_in : '0;
        bram.r_addr_out = issue ? rd_addr : r_addr_q;
        tap_sample_out  = tap_q;
        frame_valid_out = state_q == DONE;
        busy_out        = state_q != IDLE;
        overrun_out     = audio_valid_in && state_q != IDLE;
    end
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            play_ptr_q <= '0;
            wrapped_q  <= 1'b0;
            rec_q      <= 1'b0;
            snap_q     <= '0;
            idx_q      <= '0;
            r_addr_q   <= '0;
            tap_q      <= '0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            play_ptr_q <= play_ptr_d;
            wrapped_q  <= wrapped_d;
            rec_q      <= rec_d;
            snap_q     <= snap_d;
            idx_q      <= idx_d;
            r_addr_q   <= r_addr_d;
            tap_q      <= tap_d;
        end
    end
endmodule

// File: tb/tb_echo_tap_scheduler.sv
// tb_echo_tap_scheduler: directed bench for echo_tap_scheduler with a 2-cycle-latency BRAM model
module tb_echo_tap_scheduler;
    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        audio_valid_in;
    logic [7:0]  audio_in;
    logic        record_in;
    logic [63:0] tap_delay_in;
    logic [3:0]  tap_en_in;
    logic [31:0] tap_sample_out;
    logic [7:0]  mix;
    logic        frame_valid_out, busy_out, overrun_out;
    logic [7:0]  mem [65536];
    logic [7:0]  rd_p1;
    int          vecs = 0;
    int          errs = 0;
    int          fv_n, ov_n;
    echo_tap_scheduler_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();
    echo_tap_scheduler dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .audio_valid_in  (audio_valid_in),
        .audio_in        (audio_in),
        .record_in       (record_in),
        .tap_delay_in    (tap_delay_in),
        .tap_en_in       (tap_en_in),
        .bram            (bus),
        .tap_sample_out  (tap_sample_out),
        .mix_out         (mix),
        .frame_valid_out (frame_valid_out),
        .busy_out        (busy_out),
        .overrun_out     (overrun_out)
    );
    always #5 clk_in = ~clk_in;
    initial for (int i = 0; i < 65536; i++) mem[i] = 8'(i);
    always @(posedge clk_in) begin
        if (bus.we_out) mem[bus.w_addr_out] <= bus.wdata_out;
        rd_p1        <= mem[bus.r_addr_out];
        bus.rdata_in <= rd_p1;
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic nxt();
        @(negedge clk_in);
        audio_valid_in = 1'b0;
        #1;
    endtask
    task automatic stb();
        audio_valid_in = 1'b1;
        #1;
    endtask
    task automatic idle(input int n);
        repeat (n) nxt();
    endtask
    task automatic adv(input int n);
        repeat (n) begin
            nxt();
            stb();
            idle(7);
        end
    endtask
    task automatic play_frame(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2, input logic [15:0] a3);
        nxt();
        stb();
        chk("overrun_idle", overrun_out, 0);
        nxt();
        chk("r_addr_t0", bus.r_addr_out, a0);
        chk("busy", busy_out, 1);
        nxt();
        chk("r_addr_t1", bus.r_addr_out, a1);
        nxt();
        chk("r_addr_t2", bus.r_addr_out, a2);
        nxt();
        chk("r_addr_t3", bus.r_addr_out, a3);
        nxt();
        nxt();
        chk("fv_early", frame_valid_out, 0);
        chk("r_addr_hold", bus.r_addr_out, a3);
        nxt();
        chk("fv_cycle7", frame_valid_out, 1);
    endtask
    initial begin
        rst_n_in       = 1'b0;
        audio_valid_in = 1'b0;
        audio_in       = 8'd0;
        record_in      = 1'b0;
        tap_delay_in   = {16'd3, 16'd2, 16'd1, 16'd0};
        tap_en_in      = 4'hF;
        idle(2);
        chk("rst_we", bus.we_out, 0);
        chk("rst_waddr", bus.w_addr_out, 0);
        chk("rst_raddr", bus.r_addr_out, 0);
        chk("rst_taps", tap_sample_out, 0);
        chk("rst_mix", mix, 0);
        chk("rst_fv", frame_valid_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_ovr", overrun_out, 0);
        rst_n_in  = 1'b1;
        record_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nxt();
            audio_in = 8'(10 + i);
            stb();
            chk("wr_we", bus.we_out, 1);
            chk("wr_addr", bus.w_addr_out, 64'(i));
            chk("wr_data", bus.wdata_out, 64'(10 + i));
            chk("wr_raddr", bus.r_addr_out, 0);
            chk("wr_nofv", frame_valid_out, 0);
            chk("wr_nobusy", busy_out, 0);
            nxt();
            chk("wr_we_off", bus.we_out, 0);
        end
        record_in = 1'b0;
        adv(4);
        play_frame(16'd4, 16'd3, 16'd2, 16'd1);
        chk("taps_fixed", tap_sample_out, {8'd11, 8'd12, 8'd13, 8'd14});
        chk("mix_fixed", mix, 8'd50);
        nxt();
        chk("fv_one_cycle", frame_valid_out, 0);
        chk("idle_busy", busy_out, 0);
        chk("taps_hold", tap_sample_out, {8'd11, 8'd12, 8'd13, 8'd14});
        record_in = 1'b1;
        nxt();
        record_in = 1'b0;
        play_frame(16'd0, 16'd65535, 16'd65534, 16'd65533);
        chk("taps_recedge", tap_sample_out, {8'd0, 8'd0, 8'd0, 8'd10});
        chk("mix_recedge", mix, 8'd10);
        adv(1);
        tap_delay_in = {16'd0, 16'd3000, 16'd1, 16'd0};
        tap_en_in    = 4'b0111;
        play_frame(16'd2, 16'd1, 16'd62538, 16'd2);
        chk("taps_underflow", tap_sample_out, {8'd0, 8'd0, 8'd11, 8'd12});
        chk("mix_underflow", mix, 8'd23);
        nxt();
        record_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nxt();
            audio_in = i < 2 ? 8'd127 : 8'h9C;
            stb();
            chk("wr2_addr", bus.w_addr_out, 64'(5 + i));
        end
        nxt();
        record_in    = 1'b0;
        tap_delay_in = {16'd0, 16'd0, 16'd1, 16'd0};
        tap_en_in    = 4'b0011;
        adv(6);
        play_frame(16'd6, 16'd5, 16'd6, 16'd6);
        chk("taps_satpos", tap_sample_out, {8'd0, 8'd0, 8'd127, 8'd127});
        chk("mix_satpos", mix, 8'h7F);
        adv(1);
        play_frame(16'd8, 16'd7, 16'd8, 16'd8);
        chk("taps_satneg", tap_sample_out, {8'd0, 8'd0, 8'h9C, 8'h9C});
        chk("mix_satneg", mix, 8'h80);
        tap_delay_in = 64'd0;
        tap_en_in    = 4'hF;
        nxt();
        stb();
        chk("ovr_c0", overrun_out, 0);
        idle(3);
        stb();
        chk("ovr_c3", overrun_out, 1);
        chk("ovr_busy", busy_out, 1);
        fv_n = 0;
        ov_n = 0;
        repeat (12) begin
            nxt();
            fv_n += int'(frame_valid_out);
            ov_n += int'(overrun_out);
        end
        chk("ovr_fv_count", 64'(fv_n), 1);
        chk("ovr_pulse_once", 64'(ov_n), 0);
        play_frame(16'd11, 16'd11, 16'd11, 16'd11);
        chk("taps_ovr", tap_sample_out, {8'h0B, 8'h0B, 8'h0B, 8'h0B});
        chk("mix_ovr", mix, 8'h2C);
        nxt();
        record_in = 1'b1;
        nxt();
        record_in = 1'b0;
        nxt();
        audio_valid_in = 1'b1;
        repeat (65535) @(negedge clk_in);
        audio_valid_in = 1'b0;
        idle(9);
        tap_delay_in = {16'd0, 16'd0, 16'd0, 16'd1};
        tap_en_in    = 4'b0001;
        play_frame(16'd65534, 16'd65535, 16'd65535, 16'd65535);
        chk("taps_prewrap", tap_sample_out, {8'd0, 8'd0, 8'd0, 8'hFE});
        chk("mix_prewrap", mix, 8'hFE);
        play_frame(16'd65535, 16'd0, 16'd0, 16'd0);
        chk("taps_wrapped", tap_sample_out, {8'd0, 8'd0, 8'd0, 8'hFF});
        chk("mix_wrapped", mix, 8'hFF);
        nxt();
        stb();
        idle(3);
        chk("mid_busy", busy_out, 1);
        rst_n_in = 1'b0;
        #1;
        chk("mid_rst_busy", busy_out, 0);
        chk("mid_rst_raddr", bus.r_addr_out, 0);
        chk("mid_rst_taps", tap_sample_out, 0);
        chk("mid_rst_mix", mix, 0);
        chk("mid_rst_fv", frame_valid_out, 0);
        chk("mid_rst_waddr", bus.w_addr_out, 0);
        nxt();
        rst_n_in = 1'b1;
        fv_n = 0;
        repeat (10) begin
            nxt();
            fv_n += int'(frame_valid_out);
        end
        chk("mid_rst_nofv", 64'(fv_n), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
